// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM encoding and the baud divider table.
package uart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned oversample,
                                           input logic [2:0]  sel);
    int unsigned ticks_per_sec;
    ticks_per_sec = oversample * baud_rate(sel);
    return (clk_freq + ticks_per_sec / 2) / ticks_per_sec;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Oversampling baud tick generator: one-clock tick every divider clocks for the selected rate.
module baud_controller #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       tick
);
  import uart_pkg::*;

  localparam int unsigned MAX_DIV = baud_div(CLK_FREQ, OVERSAMPLE, 3'd0);
  localparam int unsigned CNT_W   = $clog2(MAX_DIV + 1);

  logic [CNT_W-1:0] div_last [8];
  logic [CNT_W-1:0] div_cnt;

  for (genvar i = 0; i < 8; i++) begin : g_div
    assign div_last[i] = CNT_W'(baud_div(CLK_FREQ, OVERSAMPLE, 3'(i)) - 1);
  end

  assign tick = !clear && (div_cnt == div_last[baud_select]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit half: start, 8 data bits LSB first, optional even parity, one stop bit.
// Parity bit is compiled in with `define UART_TX_PARITY_EN; otherwise frames are 8N1.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY
);
  import uart_pkg::*;

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  logic [2:0]        state;
  logic [2:0]        baud_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic              txd_q;
  logic              busy_q;
  logic              tick;
  logic              accept;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  assign accept  = Tx_WR && Tx_EN && !busy_q && (state == IDLE);
  assign bit_end = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

  baud_controller #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_q),
    .clear       (accept),
    .tick        (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_q   <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (bit_end) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            shift    <= Tx_DATA;
            baud_q   <= baud_select;
            tick_cnt <= '0;
            bit_idx  <= '0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^Tx_DATA;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            txd_q <= shift[0];
            shift <= shift >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd_q <= parity_q;
`else
              state <= STOP;
              txd_q <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd_q   <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd_q <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-level reference model plus directed/random writes.
module tb_uart_transmitter;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BIT7    = 432;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int FRAME7  = 4752;
  localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] EXP_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] EXP_5A = 11'b1_0_01011010_0;
`else
  localparam int NBITS   = 10;
  localparam int FRAME7  = 4320;
  localparam logic [10:0] EXP_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] EXP_07 = 11'b0_1_00000111_0;
  localparam logic [10:0] EXP_5A = 11'b0_1_01011010_0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Tx_DATA = '0;
  logic [2:0] baud_select = 3'd7;
  logic       Tx_EN = 1'b1;
  logic       Tx_WR = 1'b0;
  logic       TxD;
  logic       Tx_BUSY;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLK_FREQ   (CLK_HZ),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  function automatic int div_for(input int sel);
    int rate;
    case (sel)
      0: rate = 300;
      1: rate = 1200;
      2: rate = 4800;
      3: rate = 9600;
      4: rate = 19200;
      5: rate = 38400;
      6: rate = 57600;
      default: rate = 115200;
    endcase
    return $rtoi(real'(CLK_HZ) / (16.0 * real'(rate)) + 0.5);
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a frame is a bit vector played out for bitlen clocks per bit.
  logic        m_active = 1'b0;
  int          m_cycle = 0;
  int          m_bitlen = BIT7;
  logic [10:0] m_frame = '1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_cycle++;
      if (m_cycle == NBITS * m_bitlen) m_active = 1'b0;
    end else if (Tx_WR && Tx_EN) begin
      m_active = 1'b1;
      m_cycle  = 0;
      m_bitlen = 16 * div_for(int'(baud_select));
      m_frame  = '0;
      m_frame[8:1] = Tx_DATA;
`ifdef UART_TX_PARITY_EN
      m_frame[9]  = ($countones(Tx_DATA) % 2) == 1;
      m_frame[10] = 1'b1;
`else
      m_frame[9]  = 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    check("line_txd", {31'b0, TxD}, {31'b0, m_active ? m_frame[m_cycle / m_bitlen] : 1'b1});
    check("line_busy", {31'b0, Tx_BUSY}, {31'b0, m_active});
  end

  task automatic write(input logic [7:0] d, input logic [2:0] sel, input logic en);
    @(negedge clk);
    Tx_DATA = d;
    baud_select = sel;
    Tx_EN = en;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  task automatic capture(output int busy_cyc, output logic [10:0] samp);
    int cyc = 0;
    samp = '0;
    while (Tx_BUSY === 1'b1 && cyc < 20000) begin
      if (cyc % BIT7 == BIT7 / 2 && cyc / BIT7 < 11) samp[cyc / BIT7] = TxD;
      cyc++;
      @(negedge clk);
    end
    busy_cyc = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (Tx_BUSY !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, n < 20000}, 32'd1);
  endtask

  task automatic count_busy(input int cycles, output int nb);
    nb = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (Tx_BUSY !== 1'b0) nb++;
    end
  endtask

  initial begin
    int          bc, nb, tr, cyc;
    logic        prev;
    logic [10:0] samp;
    logic [7:0]  d;

    check("model_div7", div_for(7), 32'd27);
    check("model_div0", div_for(0), 32'd10417);

    repeat (5) @(negedge clk);
    check("reset_txd", {31'b0, TxD}, 32'd1);
    check("reset_busy", {31'b0, Tx_BUSY}, 32'd0);
    reset = 1'b0;

    tr = 0;
    prev = TxD;
    repeat (10000) begin
      @(negedge clk);
      if (TxD !== prev) tr++;
      prev = TxD;
    end
    check("idle_transitions", tr, 32'd0);

    write(8'hA5, 3'd7, 1'b1);
    capture(bc, samp);
    check("a5_busy_len", bc, FRAME7);
    check("a5_bits", {21'b0, samp}, {21'b0, EXP_A5});

    repeat (10) @(negedge clk);
    write(8'h07, 3'd7, 1'b1);
    capture(bc, samp);
    check("07_busy_len", bc, FRAME7);
    check("07_bits", {21'b0, samp}, {21'b0, EXP_07});

    write(8'h81, 3'd7, 1'b1);
    repeat (1000) @(negedge clk);
    Tx_DATA = 8'hFF;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    wait_idle("busywr_idle");
    count_busy(300, nb);
    check("busywr_no_second", nb, 32'd0);

    write(8'h96, 3'd7, 1'b1);
    wait_idle("b2b_first_idle");
    check("b2b_gap_txd", {31'b0, TxD}, 32'd1);
    Tx_DATA = 8'h3C;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    check("b2b_busy", {31'b0, Tx_BUSY}, 32'd1);
    check("b2b_txd", {31'b0, TxD}, 32'd0);
    cyc = 0;
    while (Tx_BUSY === 1'b1 && cyc < 20000) begin
      if (cyc == 1000) begin
        Tx_EN = 1'b0;
        baud_select = 3'd0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_len_baud_change", cyc, FRAME7);
    Tx_EN = 1'b1;
    baud_select = 3'd7;

    write(8'h55, 3'd7, 1'b0);
    count_busy(200, nb);
    check("en_low_no_frame", nb, 32'd0);
    Tx_EN = 1'b1;

    for (int s = 2; s <= 6; s++) begin
      write(8'h00, 3'(s), 1'b1);
      repeat (16 * div_for(s) + 40) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0;
    end

    write(8'h00, 3'd7, 1'b1);
    repeat (4 * BIT7 + 100) @(negedge clk);
    check("pre_reset_txd", {31'b0, TxD}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_txd", {31'b0, TxD}, 32'd1);
    check("async_reset_busy", {31'b0, Tx_BUSY}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    write(8'h5A, 3'd7, 1'b1);
    capture(bc, samp);
    check("5a_busy_len", bc, FRAME7);
    check("5a_bits", {21'b0, samp}, {21'b0, EXP_5A});

    repeat (3) begin
      d = 8'($urandom);
      write(d, 3'd7, $urandom_range(0, 3) != 0);
      wait_idle("rand_idle");
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
